// File: rtl/vga_timing_scaler.sv
// Raster timing generator with integer pixel replication and a delayed output
// stage, so sync/blank line up with a pixel FIFO of fixed read latency.
module vga_timing_scaler #(
  parameter int C_resolution_x      = 640,
  parameter int C_hsync_front_porch = 16,
  parameter int C_hsync_pulse       = 96,
  parameter int C_hsync_back_porch  = 48,
  parameter int C_resolution_y      = 480,
  parameter int C_vsync_front_porch = 10,
  parameter int C_vsync_pulse       = 2,
  parameter int C_vsync_back_porch  = 33,
  parameter int C_hsync_polarity    = 0,
  parameter int C_vsync_polarity    = 0,
  parameter int C_scale_x           = 1,
  parameter int C_scale_y           = 1,
  parameter int C_latency           = 0,
  parameter int C_color_bits        = 8
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  output logic                    fetch_next,
  output logic                    line_repeat,
  output logic                    frame_start,
  output logic [11:0]             beam_x,
  output logic [10:0]             beam_y,
  input  logic [C_color_bits-1:0] red_byte,
  input  logic [C_color_bits-1:0] green_byte,
  input  logic [C_color_bits-1:0] blue_byte,
  output logic [C_color_bits-1:0] vga_r,
  output logic [C_color_bits-1:0] vga_g,
  output logic [C_color_bits-1:0] vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_vblank,
  output logic                    vga_blank,
  output logic                    vga_de
);

  localparam int FX = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
  localparam int FY = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;

  localparam logic [11:0] X_RES  = 12'(C_resolution_x);
  localparam logic [11:0] X_HS0  = 12'(C_resolution_x + C_hsync_front_porch);
  localparam logic [11:0] X_HS1  = 12'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [11:0] X_LAST = 12'(FX - 1);
  localparam logic [10:0] Y_RES  = 11'(C_resolution_y);
  localparam logic [10:0] Y_VS0  = 11'(C_resolution_y + C_vsync_front_porch);
  localparam logic [10:0] Y_VS1  = 11'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
  localparam logic [10:0] Y_LAST = 11'(FY - 1);
  localparam logic [1:0]  SX_LAST = 2'(C_scale_x - 1);
  localparam logic [1:0]  SY_LAST = 2'(C_scale_y - 1);
  localparam logic        HS_POL = 1'(C_hsync_polarity);
  localparam logic        VS_POL = 1'(C_vsync_polarity);

  if ((C_scale_x < 1) || (C_scale_x > 4) ||
      ((C_resolution_x % ((C_scale_x < 1) ? 1 : C_scale_x)) != 0)) begin : g_bad_scale_x
    $error("vga_timing_scaler: C_scale_x must be 1..4 and divide C_resolution_x");
  end
  if ((C_scale_y < 1) || (C_scale_y > 4) ||
      ((C_resolution_y % ((C_scale_y < 1) ? 1 : C_scale_y)) != 0)) begin : g_bad_scale_y
    $error("vga_timing_scaler: C_scale_y must be 1..4 and divide C_resolution_y");
  end
  if ((C_latency < 0) || (C_latency > 7)) begin : g_bad_latency
    $error("vga_timing_scaler: C_latency must be 0..7");
  end

  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [1:0]  sub_x_q, sub_x_d;
  logic [1:0]  sub_y_q, sub_y_d;
  logic        x_wrap, y_wrap;
  logic        active0, hs0, vs0, vb0;
  logic [3:0]  stage0, stage_del;

  always_comb begin
    x_wrap  = (x_q == X_LAST);
    y_wrap  = (y_q == Y_LAST);
    x_d     = x_wrap ? 12'd0 : x_q + 12'd1;
    y_d     = y_q;
    sub_x_d = sub_x_q;
    sub_y_d = sub_y_q;
    if (x_wrap) begin
      sub_x_d = 2'd0;
    end else if (x_q < X_RES) begin
      sub_x_d = (sub_x_q == SX_LAST) ? 2'd0 : sub_x_q + 2'd1;
    end
    if (x_wrap) begin
      y_d = y_wrap ? 11'd0 : y_q + 11'd1;
      if (y_wrap) begin
        sub_y_d = 2'd0;
      end else if (y_q < Y_RES) begin
        sub_y_d = (sub_y_q == SY_LAST) ? 2'd0 : sub_y_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      sub_x_q <= '0;
      sub_y_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sub_x_q <= sub_x_d;
      sub_y_q <= sub_y_d;
    end
  end

  always_comb begin
    active0 = (x_q < X_RES) && (y_q < Y_RES);
    hs0     = (x_q >= X_HS0) && (x_q < X_HS1);
    vs0     = (y_q >= Y_VS0) && (y_q < Y_VS1);
    vb0     = (y_q >= Y_RES);
    stage0  = {active0, hs0, vs0, vb0};
  end

  assign fetch_next  = active0 && (sub_x_q == 2'd0);
  // Looks ahead at the line about to start: replay when it is a repeated row.
  assign line_repeat = x_wrap && (y_d < Y_RES) && (sub_y_d != 2'd0);
  assign frame_start = (x_q == 12'd0) && (y_q == 11'd0);
  assign beam_x      = x_q;
  assign beam_y      = y_q;

  if (C_latency > 0) begin : g_delay
    logic [3:0] sr_q [C_latency];
    always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < C_latency; i++) sr_q[i] <= '0;
      end else begin
        for (int i = C_latency - 1; i > 0; i--) sr_q[i] <= sr_q[i-1];
        sr_q[0] <= stage0;
      end
    end
    assign stage_del = sr_q[C_latency-1];
  end else begin : g_no_delay
    assign stage_del = stage0;
  end

  logic                    de_q, blank_q, vblank_q, hsync_q, vsync_q;
  logic [C_color_bits-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      de_q     <= 1'b0;
      blank_q  <= 1'b1;
      vblank_q <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      de_q     <= stage_del[3];
      blank_q  <= ~stage_del[3];
      vblank_q <= stage_del[0];
      hsync_q  <= ~(stage_del[2] ^ HS_POL);
      vsync_q  <= ~(stage_del[1] ^ VS_POL);
      r_q      <= stage_del[3] ? red_byte   : '0;
      g_q      <= stage_del[3] ? green_byte : '0;
      b_q      <= stage_del[3] ? blue_byte  : '0;
    end
  end

  assign vga_de     = de_q;
  assign vga_blank  = blank_q;
  assign vga_vblank = vblank_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Bench for vga_timing_scaler: two instances on an 8x4 raster (frame 14x7)
// compared every cycle against a position-from-time arithmetic model.
module tb_vga_timing_scaler;

  typedef struct packed {
    logic        fetch;
    logic        lrep;
    logic        fstart;
    logic [11:0] bx;
    logic [10:0] by;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        vblank;
    logic        blank;
    logic        de;
  } out_t;

  typedef struct {
    int         k;
    logic       de;
    logic [7:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] ra, ga, ba, rb, gb, bb;

  logic        fn_a, lr_a, fs_a, hs_a, vs_a, vbl_a, bl_a, de_a;
  logic [11:0] bx_a;
  logic [10:0] by_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        fn_b, lr_b, fs_b, hs_b, vs_b, vbl_b, bl_b, de_b;
  logic [11:0] bx_b;
  logic [10:0] by_b;
  logic [7:0]  r_b, g_b, b_b;

  vga_timing_scaler #(
    .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(1), .C_vsync_polarity(1), .C_scale_x(1), .C_scale_y(1),
    .C_latency(0), .C_color_bits(8)
  ) dut_a (
    .clk_pixel(clk), .reset_n(rst_n), .fetch_next(fn_a), .line_repeat(lr_a),
    .frame_start(fs_a), .beam_x(bx_a), .beam_y(by_a),
    .red_byte(ra), .green_byte(ga), .blue_byte(ba),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
    .vga_vblank(vbl_a), .vga_blank(bl_a), .vga_de(de_a)
  );

  vga_timing_scaler #(
    .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(0), .C_vsync_polarity(0), .C_scale_x(2), .C_scale_y(2),
    .C_latency(3), .C_color_bits(8)
  ) dut_b (
    .clk_pixel(clk), .reset_n(rst_n), .fetch_next(fn_b), .line_repeat(lr_b),
    .frame_start(fs_b), .beam_x(bx_b), .beam_y(by_b),
    .red_byte(rb), .green_byte(gb), .blue_byte(bb),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
    .vga_vblank(vbl_b), .vga_blank(bl_b), .vga_de(de_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int kc      = 0;
  int cnt_fetch_a = 0, cnt_fetch_b = 0, cnt_lrep_b = 0;

  // Raster position after n edges is n mod 98; registered outputs after
  // edge k reflect position k-1-latency (pipeline reset values before that).
  function automatic out_t model(int k, int pol, int sx, int sy, int lat,
                                 logic [7:0] ir, logic [7:0] ig, logic [7:0] ib);
    out_t o;
    int x, y, ny, m, mx, my;
    logic act, p;
    p  = (pol != 0);
    x  = (k % 98) % 14;
    y  = (k % 98) / 14;
    ny = (y + 1) % 7;
    o.bx     = 12'(x);
    o.by     = 11'(y);
    o.fstart = ((k % 98) == 0);
    o.fetch  = (x < 8) && (y < 4) && ((x % sx) == 0);
    o.lrep   = (x == 13) && (ny < 4) && ((ny % sy) != 0);
    m = k - 1 - lat;
    if (m < 0) begin
      o.de = 1'b0; o.blank = 1'b1; o.vblank = 1'b0;
      o.hs = ~p;   o.vs = ~p;
      o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
    end else begin
      mx  = (m % 98) % 14;
      my  = (m % 98) / 14;
      act = (mx < 8) && (my < 4);
      o.de     = act;
      o.blank  = ~act;
      o.vblank = (my >= 4);
      o.hs     = (mx >= 10 && mx < 12) ? p : ~p;
      o.vs     = (my == 5) ? p : ~p;
      o.r = act ? ir : 8'h00;
      o.g = act ? ig : 8'h00;
      o.b = act ? ib : 8'h00;
    end
    return o;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, kc, act, exp);
    end
  endtask

  task automatic check_inst(string tag, out_t a, out_t e);
    cmp({tag, ".ctrl"},  {61'd0, a.fetch, a.lrep, a.fstart}, {61'd0, e.fetch, e.lrep, e.fstart});
    cmp({tag, ".beam"},  {41'd0, a.bx, a.by}, {41'd0, e.bx, e.by});
    cmp({tag, ".rgb"},   {40'd0, a.r, a.g, a.b}, {40'd0, e.r, e.g, e.b});
    cmp({tag, ".sync"},  {62'd0, a.hs, a.vs}, {62'd0, e.hs, e.vs});
    cmp({tag, ".blank"}, {61'd0, a.vblank, a.blank, a.de}, {61'd0, e.vblank, e.blank, e.de});
  endtask

  task automatic check_all(string phase, int k);
    out_t aa, ab;
    kc = k;
    aa = {fn_a, lr_a, fs_a, bx_a, by_a, r_a, g_a, b_a, hs_a, vs_a, vbl_a, bl_a, de_a};
    ab = {fn_b, lr_b, fs_b, bx_b, by_b, r_b, g_b, b_b, hs_b, vs_b, vbl_b, bl_b, de_b};
    check_inst({phase, ".a"}, aa, model(k, 1, 1, 1, 0, ra, ga, ba));
    check_inst({phase, ".b"}, ab, model(k, 0, 2, 2, 3, rb, gb, bb));
  endtask

  task automatic new_inputs(logic fixed_red);
    ra = 8'($urandom); ga = 8'($urandom); ba = 8'($urandom);
    rb = fixed_red ? 8'hA5 : 8'($urandom);
    gb = 8'($urandom); bb = 8'($urandom);
  endtask

  vec_t tbl [7];
  int   ti;
  int   last_fs, n_fs;

  initial begin
    tbl[0] = '{3,  1'b0, 8'h00};
    tbl[1] = '{4,  1'b1, 8'hA5};
    tbl[2] = '{11, 1'b1, 8'hA5};
    tbl[3] = '{12, 1'b0, 8'h00};
    tbl[4] = '{18, 1'b1, 8'hA5};
    tbl[5] = '{46, 1'b1, 8'hA5};
    tbl[6] = '{60, 1'b0, 8'h00};
    ti = 0;

    rst_n = 1'b0;
    new_inputs(1'b1);
    repeat (3) @(negedge clk);
    check_all("reset", 0);

    // Phase 1: first frame and a bit, red of instance b held at 0xA5.
    rst_n = 1'b1;
    check_all("run1", 0);
    if (fn_a) cnt_fetch_a++;
    if (fn_b) cnt_fetch_b++;
    if (lr_b) cnt_lrep_b++;
    new_inputs(1'b1);
    for (int k = 1; k <= 131; k++) begin
      @(negedge clk);
      check_all("run1", k);
      if (ti < 7 && tbl[ti].k == k) begin
        cmp("tbl.de", {63'd0, de_b}, {63'd0, tbl[ti].de});
        cmp("tbl.r",  {56'd0, r_b},  {56'd0, tbl[ti].r});
        ti++;
      end
      if (k < 98) begin
        if (fn_a) cnt_fetch_a++;
        if (fn_b) cnt_fetch_b++;
        if (lr_b) cnt_lrep_b++;
      end
      new_inputs(1'b1);
    end
    kc = 98;
    cmp("tbl.applied", 64'(ti), 64'd7);
    cmp("fetch_per_frame.a", 64'(cnt_fetch_a), 64'd32);
    cmp("fetch_per_frame.b", 64'(cnt_fetch_b), 64'd16);
    cmp("lrep_per_frame.b",  64'(cnt_lrep_b),  64'd2);
    kc = 131;
    cmp("pos_before_reset", {41'd0, bx_a, by_a}, {41'd0, 12'd5, 11'd2});

    // Asynchronous reset between edges at (5,2); outputs must clear at once.
    #1 rst_n = 1'b0;
    #1 check_all("async_rst", 0);
    repeat (2) begin
      @(negedge clk);
      check_all("held_rst", 0);
    end

    rst_n = 1'b1;
    last_fs = -98;
    n_fs = 0;
    for (int k = 0; k <= 250; k++) begin
      if (k > 0) @(negedge clk);
      check_all("run2", k);
      if (fs_a) begin
        kc = k;
        cmp("fs_interval", 64'(k - last_fs), 64'd98);
        last_fs = k;
        n_fs++;
      end
      new_inputs(1'b0);
    end
    cmp("fs_count", 64'(n_fs), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout k=%0d actual=running required=finished", kc);
    $fatal(1, "timeout");
  end

endmodule
